// File: rtl/mux_sel_scanner.sv
// Purpose: round-robin select generator for a 4:1 mux, with auto dwell or manual step, skipping masked channels.
// Latency: every output is registered, so a cause is visible on the next clk edge.
// Backpressure: none; en=0 or an empty mask parks the scanner in IDLE on channel 00.
module mux_sel_scanner #(
    parameter int DWELL = 4,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] mask,
    input  logic       mode,
    input  logic       step_btn,
    output logic       b0,
    output logic       b1,
    output logic       sel_valid,
    output logic       wrap
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic               vld_q, vld_d;
    logic               wrap_q, wrap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               btn_q;
    logic               mode_q;

    logic               step_edge;
    logic               mode_chg;
    logic               dwell_done;
    logic               forced;
    logic               advance;
    logic [1:0]         nxt_ch;

    // Search cur+1, cur+2, cur+3 and finally cur itself; nearer candidates win.
    function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] idx;
        logic [1:0] res;
        res = cur;
        for (int k = 3; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (m[idx]) res = idx;
        end
        return res;
    endfunction

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] res;
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) res = 2'(i);
        end
        return res;
    endfunction

    assign step_edge  = step_btn & ~btn_q;
    assign mode_chg   = mode ^ mode_q;
    assign dwell_done = ~mode & ~mode_chg & (cnt_q == DWELL_M1);
    assign forced     = ~mask[sel_q];
    assign advance    = forced | dwell_done | (mode & step_edge);
    assign nxt_ch     = next_ch(sel_q, mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            btn_q   <= step_btn;
            mode_q  <= mode;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en && (mask != 4'b0000)) state_d = SCAN;
            SCAN:    if (!en || (mask == 4'b0000)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Leaving SCAN falls through to the defaults: channel 00, invalid, no wrap.
    always_comb begin
        sel_d  = 2'b00;
        vld_d  = 1'b0;
        wrap_d = 1'b0;
        cnt_d  = '0;
        case (state_q)
            IDLE: begin
                if (state_d == SCAN) begin
                    sel_d = lowest_ch(mask);
                    vld_d = 1'b1;
                end
            end
            SCAN: begin
                if (state_d == SCAN) begin
                    vld_d = 1'b1;
                    if (advance) begin
                        sel_d  = nxt_ch;
                        wrap_d = (nxt_ch <= sel_q);
                    end else begin
                        sel_d = sel_q;
                        if (!mode && !mode_chg) cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign b1        = sel_q[1];
    assign b0        = sel_q[0];
    assign sel_valid = vld_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Purpose: table-driven check of mux_sel_scanner with a per-cycle expectation queue.
// Latency: each vector's expectation is compared one edge after its inputs are applied.
// Backpressure: none; one vector is applied and one expectation retired per clock.
module tb_mux_sel_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic       mode = 1'b0;
    logic       step_btn = 1'b0;
    logic       b0, b1, sel_valid, wrap;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] mask;
        logic       mode;
        logic       btn;
        logic [1:0] sel;
        logic       vld;
        logic       wrap;
        int         tag;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    mux_sel_scanner #(.DWELL(4), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mask      (mask),
        .mode      (mode),
        .step_btn  (step_btn),
        .b0        (b0),
        .b1        (b1),
        .sel_valid (sel_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int tag, input logic rst, input logic e, input logic [3:0] m,
                                input logic md, input logic btn, input logic [1:0] s,
                                input logic v, input logic w);
        vec_t r;
        r.rst = rst; r.en = e; r.mask = m; r.mode = md; r.btn = btn;
        r.sel = s; r.vld = v; r.wrap = w; r.tag = tag;
        return r;
    endfunction

    function automatic void add(input int tag, input logic rst, input logic e, input logic [3:0] m,
                                input logic md, input logic btn, input logic [1:0] s,
                                input logic v, input logic w);
        tbl.push_back(mk(tag, rst, e, m, md, btn, s, v, w));
    endfunction

    task automatic drive(input vec_t v);
        vec_t ex;
        reset    = v.rst;
        en       = v.en;
        mask     = v.mask;
        mode     = v.mode;
        step_btn = v.btn;
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        ex = sb.pop_front();
        n_cmp++;
        if ({b1, b0} != ex.sel || sel_valid !== ex.vld || wrap !== ex.wrap) begin
            n_bad++;
            $display("FAIL seq%0d_cmp%0d: got sel=%b vld=%b wrap=%b, want sel=%b vld=%b wrap=%b",
                     ex.tag, n_cmp, {b1, b0}, sel_valid, wrap, ex.sel, ex.vld, ex.wrap);
        end
    endtask

    initial begin
        // Reset state
        add(0, 1, 0, 4'hF, 0, 0, 2'd0, 0, 0);
        // Full mask, auto dwell of 4, wrap on return to 00
        for (int k = 0; k < 20; k++)
            add(1, 0, 1, 4'hF, 0, 0, 2'((k / 4) % 4), 1, k == 16);
        // mask 1010: alternates 01/11, wrap on 11->01
        add(2, 0, 0, 4'hF, 0, 0, 2'd0, 0, 0);
        for (int k = 0; k < 16; k++)
            add(2, 0, 1, 4'hA, 0, 0, ((k / 4) % 2 == 1) ? 2'd3 : 2'd1, 1, k == 8);
        // Single channel: stays on 10, wraps every dwell
        add(3, 0, 0, 4'hA, 0, 0, 2'd0, 0, 0);
        for (int k = 0; k < 13; k++)
            add(3, 0, 1, 4'h4, 0, 0, 2'd2, 1, (k > 0) && (k % 4 == 0));
        // Manual: held button gives one step, then single pulses
        add(4, 0, 0, 4'hF, 1, 0, 2'd0, 0, 0);
        add(4, 0, 1, 4'hF, 1, 0, 2'd0, 1, 0);
        for (int k = 0; k < 5; k++)
            add(4, 0, 1, 4'hF, 1, 1, 2'd1, 1, 0);
        add(4, 0, 1, 4'hF, 1, 0, 2'd1, 1, 0);
        add(4, 0, 1, 4'hF, 1, 1, 2'd2, 1, 0);
        add(4, 0, 1, 4'hF, 1, 0, 2'd2, 1, 0);
        add(4, 0, 1, 4'hF, 1, 1, 2'd3, 1, 0);
        add(4, 0, 1, 4'hF, 1, 0, 2'd3, 1, 0);
        add(4, 0, 1, 4'hF, 1, 1, 2'd0, 1, 1);
        for (int k = 0; k < 3; k++)
            add(4, 0, 1, 4'hF, 1, 0, 2'd0, 1, 0);
        // Button held across IDLE->SCAN must not step
        add(5, 0, 0, 4'hF, 1, 1, 2'd0, 0, 0);
        add(5, 0, 1, 4'hF, 1, 1, 2'd0, 1, 0);
        add(5, 0, 1, 4'hF, 1, 1, 2'd0, 1, 0);
        add(5, 0, 1, 4'hF, 1, 0, 2'd0, 1, 0);
        add(5, 0, 1, 4'hF, 1, 1, 2'd1, 1, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++)
            drive(tbl[i]);

        // Current channel masked off mid-dwell, then empty mask
        drive(mk(6, 0, 0, 4'hF, 0, 0, 2'd0, 0, 0));
        for (int k = 0; k < 9; k++)
            drive(mk(6, 0, 1, 4'hF, 0, 0, 2'(k / 4), 1, 0));
        drive(mk(6, 0, 1, 4'hB, 0, 0, 2'd3, 1, 0));
        for (int k = 0; k < 3; k++)
            drive(mk(6, 0, 1, 4'hB, 0, 0, 2'd3, 1, 0));
        drive(mk(6, 0, 1, 4'h0, 0, 0, 2'd0, 0, 0));

        // Reset while on 11 with counter at 2, then re-entry on lowest enabled channel
        for (int k = 0; k < 15; k++)
            drive(mk(7, 0, 1, 4'hF, 0, 0, 2'(k / 4), 1, 0));
        drive(mk(7, 1, 1, 4'hF, 0, 0, 2'd0, 0, 0));
        drive(mk(7, 0, 1, 4'hC, 0, 0, 2'd2, 1, 0));
        drive(mk(7, 0, 1, 4'hC, 0, 0, 2'd2, 1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_scanner.md
Name: mux_sel_scanner

Overview:
- Sequential select generator that drives the b1/b0 select inputs of the downstream 4:1 mux.
- Scans the four data channels round-robin. Each enabled channel is held for a programmable dwell time (auto mode), or the scan advances one channel per button press (manual mode).
- Disabled channels are skipped.
- A one-cycle wrap pulse marks each completed scan pass for the display/counter logic that follows.

Parameters:
- DWELL, 4, cycles each channel stays selected in auto mode (legal range 1..2^CNT_W)
- CNT_W, 3, dwell counter width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  scan enable; 0 forces IDLE
- mask  input  4  channel enable, bit i = channel i (i = {b1,b0})
- mode  input  1  0 = auto dwell scan, 1 = manual step
- step_btn  input  1  manual advance request, level input, rising-edge detected internally
- b0  output  1  select LSB to mux
- b1  output  1  select MSB to mux
- sel_valid  output  1  1 when b1/b0 addresses an enabled channel in SCAN
- wrap  output  1  one-cycle pulse when the selection wraps from a higher to a lower-or-equal index

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Reset has priority over every other input.
- All outputs are registered. A change is visible on the clock edge after the condition that causes it.

Reset values:
- b1b0 = 00, sel_valid = 0, wrap = 0.
- Dwell counter = 0, state = IDLE.
- step_btn edge register = 0.

States: IDLE, SCAN.

IDLE:
- b1b0 = 00, sel_valid = 0, counter = 0.
- If en = 1 and mask != 0: move to SCAN. Load b1b0 with the lowest-index set bit of mask. sel_valid = 1, counter = 0, wrap = 0.

SCAN:
- If en = 0 or mask == 0: return to IDLE next edge. b1b0 -> 00, sel_valid -> 0, no wrap pulse.
- Next-channel rule: search upward from cur+1, modulo 4, and take the first index whose mask bit is 1. The search includes cur itself as the last candidate.
- wrap = 1 for one cycle exactly when next <= cur. This includes the single-enabled-channel case, where next == cur.
- Auto mode (mode = 0):
  - Counter increments each cycle.
  - When counter == DWELL-1: advance to the next channel and clear the counter.
  - DWELL = 1 advances every cycle.
- Manual mode (mode = 1):
  - Counter holds at 0.
  - Advance once per rising edge of step_btn (step_btn = 1 and previous sample = 0).
  - A held button gives exactly one step.
- Mode switch: the counter clears on any mode change. Auto dwell restarts from 0 after returning to mode = 0.
- Current channel masked off (mask[cur] = 0, mask != 0): advance on the next edge regardless of counter or mode, and clear the counter. The wrap rule applies.
- Simultaneous events: at most one advance per cycle. A forced advance (masked current) and a dwell or step advance in the same cycle count as one advance.
- The edge register for step_btn samples every cycle in every state, so a press held across IDLE->SCAN does not cause a step.
- Reset asserted mid-scan: next edge returns to reset values, with no wrap pulse.

Test Plan:
- Reset, then en = 1, mask = 1111, mode = 0, DWELL = 4:
  - b1b0 follows 00 (1 cycle after en), then 01, 10, 11, 00, each held 4 cycles.
  - wrap = 1 only in the cycle b1b0 returns to 00.
  - sel_valid = 1 throughout.
- mask = 1010, auto mode:
  - Sequence 01, 11, 01, 11.
  - wrap pulses on each 11->01 transition.
  - Channels 0 and 2 are never selected.
- mask = 0100, auto mode:
  - b1b0 stays 10.
  - wrap pulses once every 4 cycles.
- mode = 1, mask = 1111:
  - step_btn held high for 5 cycles advances exactly one channel (00->01).
  - Three separate 1-cycle pulses give 01->10->11->00, with wrap on the last.
  - No movement without pulses.
- While on channel 10 in auto mode, clear mask[2] (mask = 1011):
  - Next edge b1b0 = 11, counter restarts.
  - Then set mask = 0000: next edge b1b0 = 00, sel_valid = 0, state IDLE.
- Assert reset for 1 cycle while b1b0 = 11, counter = 2:
  - Next edge b1b0 = 00, sel_valid = 0, wrap = 0.
  - With en held at 1, one further edge gives SCAN with b1b0 = lowest enabled channel.
